fib_arbiter: RTL and testbench

- Shares one fib function core (start/ready/done/result handshake) among N_REQ independent requesters using round-robin arbitration.
- Sequences each job: accept, issue, wait for done, return the result.
- Runs a watchdog per job. If the core hangs, the block pulses the core's active-low reset and returns an error response.
- Sits between requester logic and the single fib instance.

---
 rtl/fib_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fib_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_arbiter.sv
`default_nettype none
// =============================================================================
// fib_arbiter : round-robin sharing of one fib core among N_REQ requesters,
//               with a per-job watchdog that resets a hung core.
// Revision    : 1.0
// =============================================================================
module fib_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 1000,
    parameter int RST_CYCLES = 10
) (
    input  logic                      __func_clock,
    input  logic                      __func_reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_n,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_error,
    output logic                      core_start,
    output logic [DATA_W-1:0]         core_n,
    input  logic                      core_ready,
    input  logic                      core_done,
    input  logic [DATA_W-1:0]         core_result,
    output logic                      core_reset,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int c_CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE   = 3'd1;
    localparam logic [2:0] c_WAIT    = 3'd2;
    localparam logic [2:0] c_RECOVER = 3'd3;
    localparam logic [2:0] c_RESP    = 3'd4;

    logic [2:0]         r_state;
    logic [ID_W-1:0]    r_rr;
    logic [ID_W-1:0]    r_grant;
    logic [DATA_W-1:0]  r_n;
    logic [DATA_W-1:0]  r_result;
    logic               r_error;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_core_rst;

    logic               w_hi_found;
    logic               w_lo_found;
    logic [ID_W-1:0]    w_hi;
    logic [ID_W-1:0]    w_lo;
    logic [ID_W-1:0]    w_win;
    logic               w_take;
    logic [DATA_W-1:0]  w_n;
    logic [N_REQ-1:0]   w_grant_oh;
    logic               w_rsp_ack;

    // Lowest valid index at/above the pointer wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= r_rr)) begin
                w_hi_found = 1'b1;
                w_hi       = ID_W'(i);
            end
            if (req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo       = ID_W'(i);
            end
        end
    end

    assign w_win  = w_hi_found ? w_hi : w_lo;
    assign w_take = (r_state == c_IDLE) && core_ready && r_core_rst && w_lo_found;

    always_comb begin
        w_n = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_n = req_n[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant_oh = N_REQ'(1) << r_grant;
    assign w_rsp_ack  = |(rsp_ready & w_grant_oh);

    always_ff @(posedge __func_clock or negedge __func_reset) begin
        if (!__func_reset) begin
            r_state    <= c_IDLE;
            r_rr       <= '0;
            r_grant    <= '0;
            r_n        <= '0;
            r_result   <= '0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
            r_core_rst <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_core_rst <= 1'b1;
                    if (w_take) begin
                        r_n     <= w_n;
                        r_grant <= w_win;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (core_done) begin
                        r_result <= core_result;
                        r_error  <= 1'b0;
                        r_state  <= c_RESP;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_result   <= '0;
                        r_error    <= 1'b1;
                        r_core_rst <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= c_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RECOVER: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_core_rst <= 1'b1;
                        r_state    <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RESP: begin
                    if (w_rsp_ack) begin
                        r_rr    <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + ID_W'(1);
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready  = w_take ? w_grant_oh_win(w_win) : '0;
    assign rsp_valid  = (r_state == c_RESP) ? w_grant_oh : '0;
    assign rsp_result = r_result;
    assign rsp_error  = r_error;
    assign core_start = (r_state == c_ISSUE);
    assign core_n     = r_n;
    assign core_reset = r_core_rst;
    assign busy       = (r_state != c_IDLE);
    assign grant_id   = r_grant;

    function automatic logic [N_REQ-1:0] w_grant_oh_win(input logic [ID_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endmodule
`default_nettype wire

// File: tb/tb_fib_arbiter.sv
`default_nettype none
// tb_fib_arbiter : directed and randomized checks of fib_arbiter against a
// transaction-level round-robin model and a behavioural fib core.
module tb_fib_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int RC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0]   req_n;
    logic [DW-1:0]     rsp_result, core_n, core_result;
    logic              rsp_error, core_start, core_ready, core_reset, busy;
    logic              core_done = 1'b0;
    logic [1:0]        grant_id;

    fib_arbiter #(.N_REQ(N), .ID_W(2), .DATA_W(DW), .TIMEOUT(TO), .RST_CYCLES(RC)) dut (
        .__func_clock (clk),
        .__func_reset (rst_n),
        .req_valid    (req_valid),
        .req_n        (req_n),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error),
        .core_start   (core_start),
        .core_n       (core_n),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .core_result  (core_result),
        .core_reset   (core_reset),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fib(input logic [DW-1:0] n);
        logic [DW-1:0] a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural fib core: fixed latency per job, or never finishes when hang=1.
    logic          hang = 1'b0;
    int            core_lat = 2;
    logic          core_busy = 1'b0;
    int            core_cnt = 0;
    logic [DW-1:0] core_res = '0;

    always @(posedge clk or negedge core_reset) begin
        if (!core_reset) begin
            core_busy <= 1'b0;
            core_done <= 1'b0;
            core_cnt  <= 0;
            core_res  <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_busy) begin
                if (core_cnt > 0) core_cnt <= core_cnt - 1;
                else if (!hang) begin
                    core_busy <= 1'b0;
                    core_done <= 1'b1;
                end
            end else if (core_start) begin
                core_busy <= 1'b1;
                core_cnt  <= core_lat;
                core_res  <= fib(core_n);
            end
        end
    end
    assign core_ready  = ~core_busy;
    assign core_result = core_res;

    int   cyc = 0, t_start = -1, t_done = -1, t_fall = -1, t_rise = -1;
    logic prev_crst = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (core_start) t_start <= cyc;
        if (core_done) t_done <= cyc;
        if (prev_crst && !core_reset) t_fall <= cyc;
        if (!prev_crst && core_reset) t_rise <= cyc;
        prev_crst <= core_reset;
    end

    // Transaction-level model: pending requests, their arguments, rr pointer.
    bit            pend [N];
    logic [DW-1:0] pn   [N];
    int            rr;
    int            nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic raise(input int i, input logic [DW-1:0] n);
        pend[i] = 1'b1;
        pn[i]   = n;
        req_valid[i] = 1'b1;
        req_n[i*DW +: DW] = n;
    endtask

    function automatic bit any_pend();
        bit a;
        a = 0;
        for (int i = 0; i < N; i++) a |= pend[i];
        return a;
    endfunction

    task automatic serve_one(input bit exp_err, input int hold, input bit rereq, input logic [DW-1:0] rn);
        int            w;
        bit            got;
        logic [DW-1:0] en, er;
        logic [N-1:0]  oh;
        #1;
        w = -1;
        for (int j = 0; j < N; j++) if (w < 0 && pend[(rr + j) % N]) w = (rr + j) % N;
        if (w < 0) return;
        oh  = N'(1) << w;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            if (req_ready != '0) got = 1;
            else tick();
        end
        chk("grant_seen", got, 1);
        chk("req_ready_onehot", req_ready, oh);
        en = pn[w];
        tick();
        if (rereq) begin
            pn[w] = rn;
            req_n[w*DW +: DW] = rn;
        end else begin
            pend[w] = 1'b0;
            req_valid[w] = 1'b0;
        end
        #1;
        chk("core_start_next", core_start, 1);
        chk("core_n", core_n, en);
        chk("grant_id", grant_id, w);
        chk("req_ready_busy", req_ready, 0);
        er  = exp_err ? '0 : fib(en);
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (rsp_valid != '0) got = 1;
        end
        chk("rsp_seen", got, 1);
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_result", rsp_result, er);
        chk("rsp_error", rsp_error, exp_err);
        chk("core_n_stable", core_n, en);
        if (!exp_err) chk("done_to_rsp", cyc - t_done, 1);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", rsp_valid, oh);
            chk("hold_result", rsp_result, er);
            chk("hold_no_grant", req_ready, 0);
        end
        rsp_ready[w] = 1'b1;
        tick();
        rsp_ready[w] = 1'b0;
        #1;
        chk("rsp_released", rsp_valid, 0);
        rr = (w + 1) % N;
    endtask

    initial begin
        int  st;
        bit  got;
        rr = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            pn[i]   = '0;
        end
        req_valid = '1;
        req_n     = '1;
        rsp_ready = '0;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_n", core_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_core_reset", core_reset, 0);
        req_valid = '0;
        req_n     = '0;
        rst_n     = 1'b1;
        #1;
        chk("core_reset_pre_edge", core_reset, 0);
        tick();
        chk("core_reset_released", core_reset, 1);

        // Single request from requester 1.
        raise(1, 6);
        serve_one(0, 0, 0, 0);

        // Back-pressure on requester 3 while requester 1 waits.
        raise(3, 3);
        raise(1, 2);
        serve_one(0, 20, 0, 0);
        serve_one(0, 0, 0, 0);

        // Edge arguments from requester 0.
        raise(0, 0);
        serve_one(0, 0, 0, 0);
        chk("busy_between", busy, 0);
        raise(0, 1);
        serve_one(0, 0, 0, 0);
        raise(3, 7);
        serve_one(0, 0, 0, 0);

        // Contention 0 and 2, with 0 re-requesting at once.
        raise(0, 5);
        raise(2, 4);
        serve_one(0, 0, 1, 6);
        serve_one(0, 0, 0, 0);
        serve_one(0, 0, 0, 0);

        // Hung core: watchdog, core reset pulse, error response.
        hang = 1'b1;
        raise(1, 7);
        serve_one(1, 0, 0, 0);
        chk("timeout_cycles", t_fall - t_start, TO + 1);
        chk("core_reset_low_cycles", t_rise - t_fall, RC);
        hang = 1'b0;
        raise(2, 2);
        serve_one(0, 0, 0, 0);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) raise(i, $urandom_range(0, 20));
            core_lat = $urandom_range(0, 6);
            if (any_pend()) serve_one(0, $urandom_range(0, 3), 0, 0);
            else begin
                #1;
                chk("idle_ready", req_ready, 0);
                chk("idle_busy", busy, 0);
                tick();
            end
        end
        for (int k = 0; k < N && any_pend(); k++) serve_one(0, 0, 0, 0);

        // Reset during WAIT.
        core_lat = 6;
        raise(2, 9);
        #1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (req_ready != '0) got = 1;
            else tick();
        end
        chk("mw_grant", req_ready, 4'b0100);
        tick();
        req_valid[2] = 1'b0;
        pend[2] = 1'b0;
        tick();
        chk("mw_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mw_busy_rst", busy, 0);
        chk("mw_core_reset", core_reset, 0);
        chk("mw_core_n", core_n, 0);
        chk("mw_rsp_valid", rsp_valid, 0);
        chk("mw_grant_id", grant_id, 0);
        chk("mw_rsp_result", rsp_result, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        rr = 0;
        st = 0;
        repeat (5) begin
            tick();
            if (rsp_valid != '0 || busy) st++;
        end
        chk("mw_no_stale", st, 0);
        raise(3, 4);
        serve_one(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
